// File: rtl/dmem_ctrl.sv
// Multi-cycle word-addressed data memory for the 16-bit CPU.
// One lw/sw at a time: IDLE -> BUSY (LATENCY cycles) -> DONE, stalling the PC meanwhile.
module dmem_ctrl #(
  parameter int ADDR_W  = 5,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [15:0]       addr,
  input  logic [15:0]       wdata,
  output logic [15:0]       rdata,
  output logic              stall,
  output logic              done,
  output logic              err,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [15:0]       dbg_data
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam int         DEPTH    = 1 << ADDR_W;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t              state;
  logic [3:0]          cnt;
  logic                bad;
  logic                op_rd;
  logic                op_wr;
  logic [ADDR_W-1:0]   a;
  logic [15:0]         wd;
  logic [15:0]         mem [DEPTH];
  logic                req;

  assign req      = mem_read | mem_write;
  assign stall    = (state == IDLE && req) || (state == BUSY);
  assign dbg_data = mem[dbg_addr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      bad   <= 1'b0;
      op_rd <= 1'b0;
      op_wr <= 1'b0;
      a     <= '0;
      wd    <= '0;
      rdata <= '0;
      done  <= 1'b0;
      err   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: if (req) begin
          a     <= addr[ADDR_W-1:0];
          wd    <= wdata;
          op_rd <= mem_read;
          op_wr <= mem_write;
          // Upper address bits set, or a conflicting read+write, make the access illegal
          bad   <= ((addr >> ADDR_W) != 16'd0) || (mem_read && mem_write);
          cnt   <= CNT_INIT;
          state <= BUSY;
        end
        BUSY: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            if (op_wr && !bad) mem[a] <= wd;
            if (op_rd) rdata <= bad ? 16'd0 : mem[a];
            done  <= 1'b1;
            err   <= bad;
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: LATENCY=2 instance for the main sequence,
// LATENCY=1 instance for back-to-back reads.
module tb_dmem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mr0 = 0, mw0 = 0, mr1 = 0, mw1 = 0;
  logic [15:0] addr0 = 0, wd0 = 0, addr1 = 0, wd1 = 0;
  logic [4:0]  dbg0 = 0, dbg1 = 0;
  logic [15:0] rdata0, rdata1, dbgd0, dbgd1;
  logic        stall0, stall1, done0, done1, err0, err1;
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  dmem_ctrl #(.ADDR_W(5), .LATENCY(2)) u0 (
    .clk(clk), .rst(rst), .mem_read(mr0), .mem_write(mw0), .addr(addr0), .wdata(wd0),
    .rdata(rdata0), .stall(stall0), .done(done0), .err(err0), .dbg_addr(dbg0), .dbg_data(dbgd0)
  );

  dmem_ctrl #(.ADDR_W(5), .LATENCY(1)) u1 (
    .clk(clk), .rst(rst), .mem_read(mr1), .mem_write(mw1), .addr(addr1), .wdata(wd1),
    .rdata(rdata1), .stall(stall1), .done(done1), .err(err1), .dbg_addr(dbg1), .dbg_data(dbgd1)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit u, input bit rd, input bit wr, input logic [15:0] a,
                       input logic [15:0] d);
    if (u) begin mr1 = rd; mw1 = wr; addr1 = a; wd1 = d; end
    else   begin mr0 = rd; mw0 = wr; addr0 = a; wd0 = d; end
  endtask

  // One full access starting in IDLE; checks stall/done every cycle and the DONE-cycle outputs.
  task automatic access(input string tag, input bit u, input bit rd, input bit wr,
                        input logic [15:0] a, input logic [15:0] d, input bit eerr,
                        input bit crd, input logic [15:0] erd);
    int lat;
    lat = u ? 1 : 2;
    @(negedge clk);
    drive(u, rd, wr, a, d);
    #1;
    chk({tag, " stall c0"}, u ? stall1 : stall0, 1);
    chk({tag, " done c0"},  u ? done1  : done0,  0);
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      chk({tag, " stall busy"}, u ? stall1 : stall0, 1);
      chk({tag, " done busy"},  u ? done1  : done0,  0);
      chk({tag, " err busy"},   u ? err1   : err0,   0);
    end
    @(negedge clk);
    chk({tag, " stall done"}, u ? stall1 : stall0, 0);
    chk({tag, " done"},       u ? done1  : done0,  1);
    chk({tag, " err"},        u ? err1   : err0,   16'(eerr));
    if (crd) chk({tag, " rdata"}, u ? rdata1 : rdata0, erd);
    drive(u, 0, 0, 0, 0);
    #1;
    chk({tag, " stall after"}, u ? stall1 : stall0, 0);
  endtask

  task automatic dbg_chk(input string tag, input bit u, input logic [4:0] a,
                         input logic [15:0] exp);
    if (u) dbg1 = a; else dbg0 = a;
    #1;
    chk(tag, u ? dbgd1 : dbgd0, exp);
  endtask

  initial begin
    #1;
    chk("por rdata", rdata0, 0);
    chk("por done",  done0,  0);
    chk("por stall", stall0, 0);
    @(negedge clk);
    rst = 1'b0;

    // Preload then reset mid-cycle
    access("pre sw7", 0, 0, 1, 16'd7, 16'h1111, 0, 0, 0);
    access("pre lw7", 0, 1, 0, 16'd7, 16'h0000, 0, 1, 16'h1111);
    #2 rst = 1'b1;
    #1;
    chk("rst rdata", rdata0, 0);
    chk("rst done",  done0,  0);
    chk("rst err",   err0,   0);
    chk("rst stall", stall0, 0);
    for (int i = 0; i < 32; i++) dbg_chk("rst dbg", 0, 5'(i), 16'h0000);
    @(negedge clk);
    rst = 1'b0;

    // sw then lw
    access("sw5", 0, 0, 1, 16'd5, 16'hBEEF, 0, 0, 0);
    dbg_chk("dbg5", 0, 5'd5, 16'hBEEF);
    access("lw5", 0, 1, 0, 16'd5, 16'h0000, 0, 1, 16'hBEEF);

    // Out-of-range write leaves array and rdata alone
    access("sw oor", 0, 0, 1, 16'h0020, 16'hAAAA, 1, 1, 16'hBEEF);
    dbg_chk("oor mem0", 0, 5'd0, 16'h0000);
    access("lw oor", 0, 1, 0, 16'h0040, 16'h0000, 1, 1, 16'h0000);

    // Read and write together
    access("sw3", 0, 0, 1, 16'd3, 16'h3333, 0, 0, 0);
    access("lw5b", 0, 1, 0, 16'd5, 16'h0000, 0, 1, 16'hBEEF);
    access("rw3", 0, 1, 1, 16'd3, 16'h0007, 1, 1, 16'h0000);
    dbg_chk("rw mem3", 0, 5'd3, 16'h3333);

    // Reset during BUSY of a write
    @(negedge clk);
    drive(0, 0, 1, 16'd9, 16'h9999);
    #1 chk("rb stall c0", stall0, 1);
    @(negedge clk);
    chk("rb stall busy", stall0, 1);
    #2 rst = 1'b1;
    drive(0, 0, 0, 0, 0);
    #1;
    chk("rb stall", stall0, 0);
    chk("rb done",  done0,  0);
    dbg_chk("rb mem9", 0, 5'd9, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("rb no done", done0, 0);
      chk("rb idle stall", stall0, 0);
    end

    // Hold: rdata survives a later write
    access("sw2", 0, 0, 1, 16'd2, 16'h1234, 0, 0, 0);
    access("lw2", 0, 1, 0, 16'd2, 16'h0000, 0, 1, 16'h1234);
    access("sw4", 0, 0, 1, 16'd4, 16'h0055, 0, 1, 16'h1234);
    dbg_chk("dbg4", 0, 5'd4, 16'h0055);
    @(negedge clk);
    chk("hold idle", rdata0, 16'h1234);

    // LATENCY=1 back-to-back accesses, 3 cycles each
    access("l1 sw1", 1, 0, 1, 16'd1, 16'hAAAA, 0, 0, 0);
    access("l1 sw2", 1, 0, 1, 16'd2, 16'hBBBB, 0, 0, 0);
    access("l1 lw1", 1, 1, 0, 16'd1, 16'h0000, 0, 1, 16'hAAAA);
    access("l1 lw2", 1, 1, 0, 16'd2, 16'h0000, 0, 1, 16'hBBBB);
    access("l1 sw oor", 1, 0, 1, 16'h8001, 16'h5555, 1, 1, 16'hBBBB);
    dbg_chk("l1 dbg1", 1, 5'd1, 16'hAAAA);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Multi-cycle data-memory stage of the 16-bit CPU, directly downstream of `alu` and upstream of the writeback `mux3X1`. It performs one word access per `lw` or `sw`:
- Address comes from the ALU `result`.
- Store data comes from register-file read port 2.
- Load data feeds `mux3X1` input `in1` (`memToReg=01`).

The block owns a word-addressed memory array. It stalls `PC_Reg` and the register-file write for the duration of the access.

## Interface
- `ADDR_W`, default 5: word-address width. Memory depth is 2^ADDR_W words of 16 bits.
- `LATENCY`, default 2: number of BUSY cycles per access. Legal range is 1..15.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `mem_read` in 1: from `control.memRead`.
- `mem_write` in 1: from `control.memWrite`.
- `addr` in 16: ALU result, used as the word address.
- `wdata` in 16: store data, `rf` read data 2.
- `rdata` out 16: registered load data.
- `stall` out 1: holds the PC and suppresses `regWrite` while high.
- `done` out 1: one-cycle pulse marking completion of an access.
- `err` out 1: one-cycle pulse, coincident with `done`, for an illegal request.
- `dbg_addr` in ADDR_W: debug read address.
- `dbg_data` out 16: combinational read of `mem[dbg_addr]`, for printing.

## Operation
- **FSM states:** IDLE, BUSY, DONE. A 4-bit down-counter `cnt` times BUSY.
- **IDLE**
  - A request is `mem_read | mem_write`.
  - On a request, at the rising edge:
    - Latch `addr[ADDR_W-1:0]`, `wdata` and the op.
    - Set the `bad` flag if `addr[15:ADDR_W] != 0` or both read and write are asserted.
    - Load `cnt = LATENCY-1` and move to BUSY.
  - With no request, stay in IDLE.
- **BUSY**
  - While `cnt != 0`: decrement `cnt` and stay in BUSY.
  - When `cnt == 0`, perform the access at the rising edge and move to DONE:
    - Write: `mem[a] <= wdata_latched`.
    - Read: `rdata <= mem[a]`.
    - If `bad`: no array write occurs, and `rdata <= 0` for any op that includes a read.
- **DONE**
  - Asserts `done`, and asserts `err` if `bad`.
  - Returns to IDLE unconditionally at the next edge.
  - Request inputs are ignored in DONE; they still belong to the completing instruction.
- **`stall`** is combinational: `(state==IDLE & request) | (state==BUSY)`. It is low in DONE, so the PC advances at the end of DONE.
- **`rdata`** holds its value until the next read completes. Writes and errors without a read never change it.
- **Array reads:**
  - `dbg_data` reads the array combinationally.
  - A read in the same cycle as an array write returns the old value.
- **No pipelining:** only one access is ever outstanding.

## Timing
- **Reset:** `rst` high asynchronously forces:
  - state IDLE, `cnt = 0`, `bad = 0`
  - `rdata = 0`, `done = 0`, `err = 0`
  - all memory words 0
- **Reset mid-operation:** an in-flight write is discarded, and an in-flight read never updates `rdata`.
- **`stall` during reset:** `stall` is combinational and can be high while `rst` is asserted if a request is present.
- **Latency** for a request first seen in IDLE at cycle 0:
  - `stall` is high for cycles 0..LATENCY.
  - DONE occurs in cycle LATENCY+1, with `rdata` valid and `done` high in that cycle.
  - Each memory instruction therefore occupies LATENCY+2 cycles.
- **LATENCY=1:** cycle 0 IDLE, cycle 1 BUSY with `cnt=0`, cycle 2 DONE.
- **Back-to-back memory instructions:** the next request is seen in IDLE the cycle after DONE. There is no zero-cycle reuse.
- **Outside accesses:** `done`, `err` and `stall` are 0 whenever no access is in progress.
- **Address wrap:** none. Out-of-range addresses take the `err` path with normal timing.

## Test plan
- **Reset:**
  - Preload via a write, then assert `rst` mid-cycle.
  - Required: immediately `rdata=0`, `done=0`, `err=0`, IDLE with `stall=0` when no request is present; `dbg_data=0` for all addresses.
- **sw then lw, LATENCY=2:**
  - Drive `mem_write`, `addr=5`, `wdata=16'hBEEF`.
  - Required: `stall` high for cycles 0–2, `done` in cycle 3, `dbg_data@5 = BEEF`.
  - Then drive `mem_read`, `addr=5`.
  - Required: `rdata = BEEF` in that access's DONE cycle; no `err` throughout.
- **Out-of-range:**
  - `mem_write` with `addr=16'h0020` (ADDR_W=5).
  - Required: same timing, `err` pulses with `done`, `mem[0]` unchanged.
  - `mem_read` with `addr=16'h0040`.
  - Required: `rdata=0`, `err=1`.
- **Both read and write asserted** with `addr=3`, `wdata=7`:
  - Required: `err` pulse, `mem[3]` unchanged, `rdata=0`.
- **Reset during BUSY of a write** to `addr=9`:
  - Required: `mem[9]` stays 0, no `done` pulse, state IDLE.
- **Hold behaviour:**
  - Read `mem[2]=16'h1234`, then write `mem[4]=16'h0055`.
  - Required: `rdata` stays `1234` through the write's DONE.
  - Repeat with back-to-back reads at LATENCY=1.
  - Required: each read takes exactly 3 cycles.
